// File: rtl/ysyx_25040129_mem_arbiter.sv
// Memory-port arbiter for the multi-cycle NPC: IFU and LSU share one slave.
// One transaction in flight; a timeout forces an error response.
module ysyx_25040129_mem_arbiter #(
  parameter int TIMEOUT    = 255,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TW         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_data,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_we,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_data,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic        we_q;
  logic        err_q;
  logic [TW-1:0] cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  wmask_q;

  logic idle;
  logic grant_lsu;
  logic tmo;
  logic resp_ifu;
  logic resp_lsu;

  // owner/last_grant: 1 = LSU, 0 = IFU
  assign idle      = rst && (state == IDLE);
  assign grant_lsu = lsu_req_valid &&
                     (!ifu_req_valid || FIXED_PRIO || !last_grant);

  assign ifu_req_ready = idle && ifu_req_valid && !grant_lsu;
  assign lsu_req_ready = idle && grant_lsu;

  // >= so an exit taken on the last cycle still leaves a bounded WAIT
  assign tmo = cnt >= TW'(TIMEOUT - 1);

  assign resp_ifu = (state == RESP) && !owner;
  assign resp_lsu = (state == RESP) && owner;

  assign mem_req_valid = (state == REQ);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  assign ifu_resp_valid = resp_ifu;
  assign ifu_resp_data  = resp_ifu ? rdata_q : 32'h0;
  assign ifu_resp_err   = resp_ifu && err_q;
  assign lsu_resp_valid = resp_lsu;
  assign lsu_resp_data  = resp_lsu ? rdata_q : 32'h0;
  assign lsu_resp_err   = resp_lsu && err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt        <= '0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      wmask_q    <= 4'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ifu_req_valid || lsu_req_valid) begin
            owner      <= grant_lsu;
            last_grant <= grant_lsu;
            cnt        <= '0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            state      <= REQ;
            if (grant_lsu) begin
              addr_q  <= lsu_addr;
              we_q    <= lsu_we;
              wdata_q <= lsu_wdata;
              wmask_q <= lsu_we ? lsu_wmask : 4'h0;
            end else begin
              addr_q  <= ifu_addr;
              we_q    <= 1'b0;
              wdata_q <= 32'h0;
              wmask_q <= 4'h0;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_req_ready) begin
            state <= WAIT;
          end else if (tmo) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            state   <= RESP;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_resp_valid) begin
            rdata_q <= we_q ? 32'h0 : mem_resp_rdata;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (tmo) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: directed scenarios then random traffic
// against a transaction-level timing/grant model; a second FIXED_PRIO copy rides along.
module tb_ysyx_25040129_mem_arbiter;

  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_addr;
  logic        lsu_req_valid;
  logic [31:0] lsu_addr;
  logic        lsu_we;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  logic        ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_ready, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_resp_data;
  logic        mem_req_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  logic        f_ifu_req_ready, f_ifu_resp_valid, f_ifu_resp_err;
  logic [31:0] f_ifu_resp_data;
  logic        f_lsu_req_ready, f_lsu_resp_valid, f_lsu_resp_err;
  logic [31:0] f_lsu_resp_data;
  logic        f_mem_req_valid, f_mem_we;
  logic [31:0] f_mem_addr, f_mem_wdata;
  logic [3:0]  f_mem_wmask;

  int n_cmp = 0;
  int n_err = 0;
  bit lg = 1'b0;

  always #5 clk = ~clk;

  ysyx_25040129_mem_arbiter #(
    .TIMEOUT(TO), .FIXED_PRIO(1'b0), .TW(8)
  ) u_dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_we(lsu_we), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
    .lsu_resp_data(lsu_resp_data), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  ysyx_25040129_mem_arbiter #(
    .TIMEOUT(TO), .FIXED_PRIO(1'b1), .TW(8)
  ) u_fp (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(f_ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(f_ifu_resp_valid),
    .ifu_resp_data(f_ifu_resp_data), .ifu_resp_err(f_ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(f_lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_we(lsu_we), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(f_lsu_resp_valid),
    .lsu_resp_data(f_lsu_resp_data), .lsu_resp_err(f_lsu_resp_err),
    .mem_req_valid(f_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(f_mem_addr), .mem_we(f_mem_we), .mem_wdata(f_mem_wdata),
    .mem_wmask(f_mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic new_ifu();
    ifu_req_valid = ($urandom_range(0, 3) != 0);
    ifu_addr      = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
  endtask

  task automatic new_lsu();
    lsu_req_valid = ($urandom_range(0, 3) != 0);
    lsu_addr      = $urandom;
    lsu_we        = 1'($urandom_range(0, 1));
    lsu_wdata     = $urandom;
    lsu_wmask     = 4'($urandom);
  endtask

  // one idle cycle with no requester valid
  task automatic idle();
    #1;
    chk("idle_ifu_ready", ifu_req_ready, 0);
    chk("idle_lsu_ready", lsu_req_ready, 0);
    step();
    chk("idle_ifu_resp", ifu_resp_valid, 0);
    chk("idle_lsu_resp", lsu_resp_valid, 0);
    chk("idle_mem_valid", mem_req_valid, 0);
    mem_resp_valid = 1'b0;
  endtask

  // Called in an IDLE cycle with at least one request presented.
  // rd: cycles the slave keeps ready low; rs: cycles from WAIT to response.
  task automatic txn(input int rd, input int rs, input logic [31:0] rdata);
    bit el, fl, tmo, ewe;
    logic [31:0] ea, ed;
    logic [3:0] em;
    int rdy_c, rsp_c, tw, rc;
    bit in_req;
    #1;
    if (ifu_req_valid && lsu_req_valid) el = !lg;
    else el = lsu_req_valid;
    fl = lsu_req_valid;
    chk("accept_mem_valid", mem_req_valid, 0);
    chk("accept_ifu_resp", ifu_resp_valid, 0);
    chk("accept_lsu_resp", lsu_resp_valid, 0);
    chk("ifu_req_ready", ifu_req_ready, !el);
    chk("lsu_req_ready", lsu_req_ready, el);
    chk("fp_ifu_req_ready", f_ifu_req_ready, !fl);
    chk("fp_lsu_req_ready", f_lsu_req_ready, fl);
    lg  = el;
    ea  = el ? lsu_addr : ifu_addr;
    ewe = el && lsu_we;
    em  = ewe ? lsu_wmask : 4'h0;
    ed  = lsu_wdata;
    // cycle numbers are relative to the accept cycle
    rdy_c = rd + 1;
    rsp_c = rd + 2 + rs;
    if (rdy_c > TO) begin
      tmo = 1'b1;
      rc  = TO + 1;
    end else begin
      tw  = (TO > rdy_c + 1) ? TO : rdy_c + 1;
      tmo = (rsp_c > tw);
      rc  = tmo ? tw + 1 : rsp_c + 1;
    end
    for (int c = 1; c <= rc; c++) begin
      step();
      in_req = (c <= rdy_c) && (c < rc);
      chk("mem_req_valid", mem_req_valid, in_req);
      if (in_req) begin
        chk("mem_addr", mem_addr, ea);
        chk("mem_we", mem_we, ewe);
        chk("mem_wmask", mem_wmask, em);
        if (ewe) chk("mem_wdata", mem_wdata, ed);
      end
      chk("ifu_resp_valid", ifu_resp_valid, (c == rc) && !el);
      chk("lsu_resp_valid", lsu_resp_valid, (c == rc) && el);
      chk("fp_lsu_resp_valid", f_lsu_resp_valid, (c == rc) && fl);
      if (c == rc) begin
        if (el) begin
          chk("lsu_resp_data", lsu_resp_data,
              (tmo || ewe) ? 32'h0 : rdata);
          chk("lsu_resp_err", lsu_resp_err, tmo);
          chk("ifu_resp_data_idle", ifu_resp_data, 0);
        end else begin
          chk("ifu_resp_data", ifu_resp_data, tmo ? 32'h0 : rdata);
          chk("ifu_resp_err", ifu_resp_err, tmo);
          chk("lsu_resp_data_idle", lsu_resp_data, 0);
        end
      end
      mem_req_ready  = (c == rdy_c);
      mem_resp_valid = (c == rsp_c) ||
                       ((c <= rdy_c) && ($urandom_range(0, 3) == 0));
      mem_resp_rdata = (c == rsp_c) ? rdata : $urandom;
      #1;
      chk("busy_ifu_ready", ifu_req_ready, 0);
      chk("busy_lsu_ready", lsu_req_ready, 0);
    end
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = tmo;
    mem_resp_rdata = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int rd, rs;
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1;
    lsu_addr = 32'h8000_2000;
    lsu_we = 1'b0;
    lsu_wdata = 32'h0;
    lsu_wmask = 4'h0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    #3 rst = 1'b0;
    step();
    step();
    chk("rst_ifu_ready", ifu_req_ready, 0);
    chk("rst_lsu_ready", lsu_req_ready, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ifu_resp", {ifu_resp_valid, ifu_resp_err, ifu_resp_data}, 0);
    chk("rst_lsu_resp", {lsu_resp_valid, lsu_resp_err, lsu_resp_data}, 0);
    rst = 1'b1;
    lg = 1'b0;
    // first tie after reset goes to LSU
    txn(0, 0, 32'h1234_5678);

    // single fetch
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b0;
    ifu_addr = 32'h8000_0000;
    txn(0, 0, 32'h0010_0073);
    ifu_req_valid = 1'b0;
    idle();

    // store then load with full mask
    lsu_req_valid = 1'b1;
    lsu_addr = 32'h8000_1000;
    lsu_we = 1'b1;
    lsu_wdata = 32'hA5A5_A5A5;
    lsu_wmask = 4'h3;
    txn(0, 0, 32'hFFFF_FFFF);
    lsu_we = 1'b0;
    lsu_wmask = 4'hF;
    txn(1, 1, 32'hDEAD_BEEF);

    // contention: both held valid, grants alternate
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0100;
    lsu_we = 1'b1;
    lsu_wmask = 4'hC;
    for (int i = 0; i < 4; i++) txn(0, 0, $urandom);

    // backpressure while the other requester waits
    txn(5, 2, 32'h0BAD_F00D);

    // timeout in WAIT, late response in IDLE, then normal
    lsu_req_valid = 1'b0;
    txn(0, 100, 32'h1111_1111);
    ifu_req_valid = 1'b0;
    idle();
    ifu_req_valid = 1'b1;
    txn(0, 0, 32'h2222_2222);
    // timeout in REQ and the exit-vs-timeout corners
    txn(TO + 3, 0, 32'h3333_3333);
    txn(4, TO - 6, 32'h4444_4444);
    txn(4, TO - 5, 32'h5555_5555);
    txn(TO - 1, 0, 32'h6666_6666);
    txn(TO - 1, 1, 32'h7777_7777);

    // reset during WAIT
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b0;
    ifu_addr = 32'h8000_0040;
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("wait_mem_valid", mem_req_valid, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_ifu_ready", ifu_req_ready, 0);
    chk("arst_mem_valid", mem_req_valid, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_ifu_resp", ifu_resp_valid, 0);
    ifu_req_valid = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hCAFE_CAFE;
    step();
    step();
    rst = 1'b1;
    lg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_ifu_resp", ifu_resp_valid, 0);
      chk("post_rst_lsu_resp", lsu_resp_valid, 0);
      chk("post_rst_mem_valid", mem_req_valid, 0);
    end
    mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    txn(0, 0, 32'h0F0F_0F0F);

    // random traffic; only the served requester changes its request
    new_ifu();
    new_lsu();
    for (int i = 0; i < 60; i++) begin
      if (!ifu_req_valid && !lsu_req_valid) begin
        idle();
        new_ifu();
        new_lsu();
      end else begin
        rd = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 4);
        rs = ($urandom_range(0, 5) == 0) ? 40 : $urandom_range(0, 5);
        txn(rd, rs, $urandom);
        if (lg) new_lsu();
        else new_ifu();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_mem_arbiter.md
Name: ysyx_25040129_mem_arbiter

Overview:
- Shares the single memory port of the multi-cycle NPC between two requesters: instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Requests are accepted one at a time through valid/ready handshakes and forwarded to the memory slave. The single response is returned to the requester that owns the transaction.
- A timeout counter guarantees forward progress when the slave never answers.

Parameters:
- TIMEOUT, 255: cycles spent in REQ+WAIT before the transaction is aborted with an error. Must be ≥ 2.
- FIXED_PRIO, 0: 0 = round-robin between IFU and LSU; 1 = LSU always wins a simultaneous request.
- TW, 8: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  fetch address
- ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
- ifu_resp_data  out  32  fetched word
- ifu_resp_err  out  1  timeout on this fetch
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  32  load/store address
- lsu_we  in  1  1 = store
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  byte enables for store
- lsu_resp_valid  out  1  one-cycle pulse, load data or store completion
- lsu_resp_data  out  32  load word (0 for stores)
- lsu_resp_err  out  1  timeout on this access
- mem_req_valid  out  1  request to slave
- mem_req_ready  in  1  slave accepts request
- mem_addr  out  32  latched address
- mem_we  out  1  latched write enable
- mem_wdata  out  32  latched write data
- mem_wmask  out  4  latched mask (0 for reads)
- mem_resp_valid  in  1  slave response
- mem_resp_rdata  in  32  slave read data

Behaviour:
- States: IDLE, REQ, WAIT, RESP. All outputs are registered or derived from state plus latched registers, except `*_req_ready`.

Reset (rst = 0, asynchronous, any state):
- state = IDLE, last_grant = IFU, counter = 0.
- All valid, ready and err outputs = 0; all data and address outputs = 0.
- An in-flight transaction is dropped and no response is issued.

IDLE:
- `*_req_ready` is combinational and only asserted in IDLE, to the selected requester.
- Only IFU valid: grant IFU. Only LSU valid: grant LSU.
- Both valid, FIXED_PRIO = 1: grant LSU.
- Both valid, FIXED_PRIO = 0: grant the requester not equal to last_grant. After reset, LSU wins the first tie.
- On grant:
  - Pulse `<owner>_req_ready` for 1 cycle.
  - Latch addr, we, wdata, wmask. IFU forces we = 0 and wmask = 0; LSU with we = 0 forces wmask = 0.
  - Record owner, update last_grant, clear counter, go to REQ.
- Requesters hold their inputs stable while valid and not ready.

REQ:
- mem_req_valid = 1; mem_* outputs carry the latched values.
- If mem_req_ready: go to WAIT. Any mem_resp_valid in the same cycle is ignored.

WAIT:
- mem_req_valid = 0.
- On mem_resp_valid: latch rdata (forced to 0 if we = 1), err = 0, go to RESP.

Timeout:
- counter increments every cycle in REQ and WAIT.
- When counter == TIMEOUT-1 without the exit condition, go to RESP with data = 0, err = 1, and deassert mem_req_valid.
- Exit and timeout in the same cycle: the exit wins.

RESP:
- `<owner>_resp_valid` = 1 for exactly one cycle, with data and err; the other requester's resp outputs stay 0.
- Next state is IDLE. No new request is accepted in RESP.

Other rules:
- mem_resp_valid outside WAIT is ignored; a late response after a timeout is discarded.
- Latency: accept at cycle t, mem_req_valid at t+1; with the slave ready at t+1 and responding at t+2, resp_valid is at t+3. Minimum turnaround between two accepts is 4 cycles.
- Address, data and mask pass through unmodified (no alignment or masking arithmetic); the counter is TW bits and never wraps because it is cleared on accept.

Test Plan:
- Single fetch: ifu_req_valid with addr 0x80000000; slave ready immediately and responds next cycle with 0x00100073 → ifu_req_ready at t, mem_req_valid at t+1 with addr 0x80000000 and we = 0, ifu_resp_valid with data 0x00100073 and err = 0 at t+3, lsu_resp_valid stays 0.
- Store: lsu addr 0x80001000, we = 1, wdata 0xA5A5A5A5, wmask 0x3 → mem_we = 1, mem_wmask = 0x3, mem_wdata 0xA5A5A5A5; lsu_resp_valid with data 0; load with lsu_wmask 0xF → mem_wmask = 0.
- Contention, FIXED_PRIO = 0: both requesters held valid continuously → grants alternate LSU, IFU, LSU, IFU; each response goes only to its owner; accepts are 4 cycles apart with a 1-cycle slave. FIXED_PRIO = 1 → LSU granted every time while it stays valid.
- Backpressure: mem_req_ready low for 5 cycles, then response 3 cycles later → mem_req_valid held 6 cycles with stable addr; exactly one resp pulse; no other accept meanwhile.
- Timeout (TIMEOUT = 8): slave never responds → resp_valid with err = 1 and data 0 at the 8th cycle after entering REQ. A late mem_resp_valid in IDLE produces no response; the next request completes normally.
- Reset mid-transaction: rst low during WAIT → all outputs 0 immediately (asynchronous), no response after release. The first tie after release is granted to LSU.
